// File: rtl/link_pkg.sv
// link_pkg: constants and types shared by the link-register / return-address
// stack controller and by instruction decode.
//   - LINK_WIDTH / LINK_DEPTH : default address width and spill-stack depth
//   - link_ptr_w / link_cnt_w : width derivation for the stack pointer and the
//                               live-entry counter (0..DEPTH+1)
//   - link_cmd_e              : decoded CALL/RET command for one cycle
package link_pkg;

  localparam int LINK_WIDTH = 8;
  localparam int LINK_DEPTH = 4;

  // Stack pointer indexes DEPTH spill slots; DEPTH is a power of two so the
  // pointer wraps naturally.
  function automatic int link_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // The counter must represent 0..DEPTH+1 (LR plus DEPTH spilled entries).
  function automatic int link_cnt_w(input int depth);
    return $clog2(depth + 2);
  endfunction

  localparam int LINK_PTR_W = link_ptr_w(LINK_DEPTH);
  localparam int LINK_CNT_W = link_cnt_w(LINK_DEPTH);

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_RET  = 2'b01,
    CMD_CALL = 2'b10,
    CMD_TAIL = 2'b11
  } link_cmd_e;

endpackage

// File: rtl/ret_stack_mem.sv
// ret_stack_mem: DEPTH x WIDTH register-file backing store for spilled return
// addresses. One synchronous write port, one asynchronous read port. No reset;
// contents are only meaningful below the controller's live count.
//   clk   in   falling-edge write clock
//   we    in   write enable
//   waddr in   write address
//   wdata in   write data
//   raddr in   read address
//   rdata out  data at raddr (combinational)
module ret_stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: writes land on the same falling edge as the rest of the
  // controller state, so a pushed entry is readable in the following cycle.
  always_ff @(negedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/link_stack_ctrl.sv
// link_stack_ctrl: link register with a hardware return-address stack.
// LR holds the newest return address; older ones spill into a circular
// DEPTH-entry stack, giving DEPTH+1 live return addresses in total.
//   clk       in   clock; all state updates on the falling edge
//   rst       in   synchronous active-high reset, highest priority
//   call_en   in   CALL: push pc_next
//   ret_en    in   RET: pop
//   pc_next   in   return address captured on CALL
//   err_clr   in   clear sticky overflow/underflow
//   lr_out    out  current LR (RET target, usable the same cycle as ret_en)
//   lr_valid  out  at least one live return address
//   depth     out  number of live return addresses, 0..DEPTH+1
//   overflow  out  sticky: CALL while already holding DEPTH+1 addresses
//   underflow out  sticky: RET while empty
module link_stack_ctrl
  import link_pkg::*;
#(
  parameter int WIDTH = LINK_WIDTH,
  parameter int DEPTH = LINK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       call_en,
  input  logic                       ret_en,
  input  logic [WIDTH-1:0]           pc_next,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           lr_out,
  output logic                       lr_valid,
  output logic [$clog2(DEPTH+2)-1:0] depth,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = link_ptr_w(DEPTH);
  localparam int CNT_W = link_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH + 1);

  logic [WIDTH-1:0] lr;
  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] count;
  logic             overflow_q;
  logic             underflow_q;

  link_cmd_e        cmd;
  logic             mem_we;
  logic [PTR_W-1:0] mem_raddr;
  logic [WIDTH-1:0] mem_rdata;

  // Command decode: both enables together is a tail call, which replaces LR
  // without touching the spill stack.
  always_comb begin
    cmd = CMD_IDLE;
    case ({call_en, ret_en})
      2'b10:   cmd = CMD_CALL;
      2'b01:   cmd = CMD_RET;
      2'b11:   cmd = CMD_TAIL;
      default: cmd = CMD_IDLE;
    endcase
  end

  // A CALL spills the old LR only when LR actually holds something. At full
  // depth sp has wrapped onto the oldest entry, so that entry is overwritten.
  assign mem_we    = (cmd == CMD_CALL) && (count != '0);
  assign mem_raddr = sp - PTR_W'(1);

  ret_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (sp),
    .wdata (lr),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // LR, stack pointer, live count and sticky flags. The flag clear is applied
  // first so that a set event later in the same cycle overrides it.
  always_ff @(negedge clk) begin
    if (rst) begin
      lr          <= '0;
      sp          <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      case (cmd)
        CMD_CALL: begin
          lr <= pc_next;
          if (count != '0) begin
            sp <= sp + PTR_W'(1);
          end
          if (count == CNT_MAX) begin
            overflow_q <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        CMD_RET: begin
          if (count >= CNT_W'(2)) begin
            lr    <= mem_rdata;
            sp    <= sp - PTR_W'(1);
            count <= count - CNT_W'(1);
          end else if (count == CNT_W'(1)) begin
            lr    <= '0;
            count <= '0;
          end else begin
            underflow_q <= 1'b1;
          end
        end
        CMD_TAIL: begin
          lr <= pc_next;
          if (count == '0) begin
            count <= CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign lr_out    = lr;
  assign lr_valid  = (count != '0);
  assign depth     = count;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_link_stack_ctrl.sv
// tb_link_stack_ctrl: directed, table-driven bench for link_stack_ctrl
// (WIDTH=8, DEPTH=4). Each vector drives one falling edge and compares the
// resulting registered outputs against hand-computed values; a few
// hand-written sequences cover same-cycle RET target and reset mid-nesting.
module tb_link_stack_ctrl;

  logic       clk;
  logic       rst;
  logic       call_en;
  logic       ret_en;
  logic [7:0] pc_next;
  logic       err_clr;
  logic [7:0] lr_out;
  logic       lr_valid;
  logic [2:0] depth;
  logic       overflow;
  logic       underflow;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic       call;
    logic       ret;
    logic       clr;
    logic [7:0] pc;
    logic [7:0] lr;
    logic [2:0] dep;
    logic       val;
    logic       ovf;
    logic       udf;
    string      name;
  } vec_t;

  vec_t vecs[$];

  link_stack_ctrl #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .pc_next   (pc_next),
    .err_clr   (err_clr),
    .lr_out    (lr_out),
    .lr_valid  (lr_valid),
    .depth     (depth),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Falling edge (the active edge) every 10 time units.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic c, input logic t,
                              input logic e, input logic [7:0] pc,
                              input logic [7:0] lr, input logic [2:0] dep,
                              input logic ovf, input logic udf,
                              input string name);
    vec_t v;
    v.rst = r; v.call = c; v.ret = t; v.clr = e; v.pc = pc;
    v.lr = lr; v.dep = dep; v.val = (dep != 3'd0); v.ovf = ovf; v.udf = udf;
    v.name = name;
    return v;
  endfunction

  task automatic driveInputs(input logic r, input logic c, input logic t,
                             input logic e, input logic [7:0] pc);
    rst = r; call_en = c; ret_en = t; err_clr = e; pc_next = pc;
  endtask

  // Drive one set of inputs across a falling edge, then settle 1 unit after.
  task automatic applyStimulus(input logic r, input logic c, input logic t,
                               input logic e, input logic [7:0] pc);
    driveInputs(r, c, t, e, pc);
    @(negedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input string field,
                            input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s.%s: got %0h expected %0h", name, field, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp_lr,
                             input logic [2:0] exp_dep, input logic exp_val,
                             input logic exp_ovf, input logic exp_udf);
    checkField(name, "lr_out",    lr_out,            exp_lr);
    checkField(name, "depth",     {5'd0, depth},     {5'd0, exp_dep});
    checkField(name, "lr_valid",  {7'd0, lr_valid},  {7'd0, exp_val});
    checkField(name, "overflow",  {7'd0, overflow},  {7'd0, exp_ovf});
    checkField(name, "underflow", {7'd0, underflow}, {7'd0, exp_udf});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    //                 rst  call ret  clr  pc     lr     dep   ovf  udf
    // Reset with a CALL held: the call must be ignored.
    vecs.push_back(mk(1, 1, 0, 0, 8'hAA, 8'h00, 3'd0, 0, 0, "rst_call0"));
    vecs.push_back(mk(1, 1, 0, 0, 8'hBB, 8'h00, 3'd0, 0, 0, "rst_call1"));
    // Call/return ordering.
    vecs.push_back(mk(0, 1, 0, 0, 8'h10, 8'h10, 3'd1, 0, 0, "call10"));
    vecs.push_back(mk(0, 1, 0, 0, 8'h20, 8'h20, 3'd2, 0, 0, "call20"));
    vecs.push_back(mk(0, 1, 0, 0, 8'h30, 8'h30, 3'd3, 0, 0, "call30"));
    vecs.push_back(mk(0, 0, 0, 0, 8'hEE, 8'h30, 3'd3, 0, 0, "idle"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h20, 3'd2, 0, 0, "ret30"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h10, 3'd1, 0, 0, "ret20"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 0, 0, "ret10"));
    // Overflow wrap; err_clr on the overflowing call loses to the set.
    vecs.push_back(mk(0, 1, 0, 0, 8'h01, 8'h01, 3'd1, 0, 0, "ovf_c1"));
    vecs.push_back(mk(0, 1, 0, 0, 8'h02, 8'h02, 3'd2, 0, 0, "ovf_c2"));
    vecs.push_back(mk(0, 1, 0, 0, 8'h03, 8'h03, 3'd3, 0, 0, "ovf_c3"));
    vecs.push_back(mk(0, 1, 0, 0, 8'h04, 8'h04, 3'd4, 0, 0, "ovf_c4"));
    vecs.push_back(mk(0, 1, 0, 0, 8'h05, 8'h05, 3'd5, 0, 0, "ovf_c5"));
    vecs.push_back(mk(0, 1, 0, 1, 8'h06, 8'h06, 3'd5, 1, 0, "ovf_c6"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h05, 3'd4, 1, 0, "ovf_r6"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h04, 3'd3, 1, 0, "ovf_r5"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h03, 3'd2, 1, 0, "ovf_r4"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h02, 3'd1, 1, 0, "ovf_r3"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 1, 0, "ovf_r2"));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0, "ovf_clr"));
    // Underflow.
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 0, 1, "udf_ret"));
    vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 1, "udf_hold"));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0, "udf_clr"));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 3'd0, 0, 1, "udf_clr_ret"));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h00, 3'd0, 0, 0, "udf_clr2"));
    // Tail call.
    vecs.push_back(mk(0, 1, 0, 0, 8'h40, 8'h40, 3'd1, 0, 0, "tail_c40"));
    vecs.push_back(mk(0, 1, 0, 0, 8'h50, 8'h50, 3'd2, 0, 0, "tail_c50"));
    vecs.push_back(mk(0, 1, 1, 0, 8'h60, 8'h60, 3'd2, 0, 0, "tail_60"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h40, 3'd1, 0, 0, "tail_r60"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 0, 0, "tail_r40"));
    vecs.push_back(mk(0, 1, 1, 0, 8'h70, 8'h70, 3'd1, 0, 0, "tail_empty"));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 3'd0, 0, 0, "tail_r70"));

    $display("[TB] applying %0d table vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].call, vecs[i].ret, vecs[i].clr, vecs[i].pc);
      checkOutput(vecs[i].name, vecs[i].lr, vecs[i].dep, vecs[i].val,
                  vecs[i].ovf, vecs[i].udf);
    end

    // RET target is LR itself: visible while ret_en is high, before the pop.
    applyStimulus(0, 1, 0, 0, 8'h81);
    applyStimulus(0, 1, 0, 0, 8'h82);
    driveInputs(0, 0, 1, 0, 8'h00);
    #1;
    checkField("same_cycle_ret", "lr_out", lr_out, 8'h82);
    checkField("same_cycle_ret", "depth", {5'd0, depth}, 8'd2);
    @(negedge clk);
    #1;
    checkOutput("same_cycle_ret_post", 8'h81, 3'd1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("same_cycle_ret_empty", 8'h00, 3'd0, 0, 0, 0);

    // Reset mid-nesting, with a RET also asserted to confirm reset priority.
    applyStimulus(0, 1, 0, 0, 8'h11);
    applyStimulus(0, 1, 0, 0, 8'h22);
    applyStimulus(0, 1, 0, 0, 8'h33);
    checkOutput("mid_pre", 8'h33, 3'd3, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 8'h00);
    checkOutput("mid_rst", 8'h00, 3'd0, 0, 0, 0);
    driveInputs(0, 0, 1, 0, 8'h00);
    #1;
    checkField("mid_ret_target", "lr_out", lr_out, 8'h00);
    @(negedge clk);
    #1;
    checkOutput("mid_ret", 8'h00, 3'd0, 0, 0, 1);

    // Stale stack contents must not resurface after reset: one call then pop.
    applyStimulus(0, 1, 0, 1, 8'h44);
    checkOutput("post_rst_call", 8'h44, 3'd1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 8'h00);
    checkOutput("post_rst_ret", 8'h00, 3'd0, 0, 0, 0);

    driveInputs(0, 0, 0, 0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
